// File: rtl/sseg_pkg.sv
// Shared 7-segment encoding: segment bit positions, hex glyphs, per-digit payload.
package sseg_pkg;

    // Bit positions within an 8-bit segment bus {dp, a, b, c, d, e, f, g}
    localparam int unsigned SEG_DP = 7;
    localparam int unsigned SEG_A  = 6;
    localparam int unsigned SEG_B  = 5;
    localparam int unsigned SEG_C  = 4;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 2;
    localparam int unsigned SEG_F  = 1;
    localparam int unsigned SEG_G  = 0;

    localparam int unsigned NUM_DIGITS = 4;

    // Active-low {a..g} glyphs for hex values 0..F, indexed by value
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // All seven segments off
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Decoded contents of one display digit
    typedef struct packed {
        logic [3:0] nibble;
        logic       dp;
        logic       blank;
        logic       err;
    } digit_t;

endpackage

// File: rtl/sseg_to_hex.sv
// Combinational decode of an active-low {a..g} pattern to a hex nibble.
module sseg_to_hex
    import sseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble_c,
    output logic       blank_c,
    output logic       err_c
);

    logic hit;

    // Table lookup; blank is its own class, anything unmatched is an error
    always_comb begin
        nibble_c = 4'd0;
        blank_c  = 1'b0;
        err_c    = 1'b0;
        hit      = 1'b0;
        if (seg == SEG_BLANK) begin
            blank_c = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (!hit && seg == SEG_HEX[i]) begin
                    nibble_c = 4'(i);
                    hit      = 1'b1;
                end
            end
            err_c = !hit;
        end
    end

endmodule

// File: rtl/sseg_mux_decoder.sv
// Samples a multiplexed 4-digit 7-segment display and rebuilds coherent frames.
module sseg_mux_decoder
    import sseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] an_in,
    input  logic [7:0] sseg_in,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] dp_out,
    output logic [3:0] blank,
    output logic [3:0] seg_err,
    output logic       frame_valid,
    output logic       an_err
);

    localparam int unsigned SAMPLE_W = 12;

    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    logic [3:0]          an_meta, s_an;
    logic [7:0]          sseg_meta, s_sseg;
    logic [SAMPLE_W-1:0] sample_c, prev_sample;
    logic                changed_c;
    logic [CNT_W-1:0]    cnt, cnt_nxt_c;
    logic [0:0]          state, state_nxt_c;
    logic                capture_c;
    logic                an_ok_c;
    logic [1:0]          slot_c;
    logic [3:0]          slot_mask_c;
    logic [3:0]          seen;
    logic                frame_pend;
    digit_t              shadow [NUM_DIGITS];
    logic [3:0]          dec_nibble_c;
    logic                dec_blank_c, dec_err_c;

    sseg_to_hex u_dec (
        .seg      (s_sseg[SEG_A:SEG_G]),
        .nibble_c (dec_nibble_c),
        .blank_c  (dec_blank_c),
        .err_c    (dec_err_c)
    );

    // Two-flop synchroniser; resets to the idle (all-off) pin levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_meta   <= 4'hF;
            s_an      <= 4'hF;
            sseg_meta <= 8'hFF;
            s_sseg    <= 8'hFF;
        end else begin
            an_meta   <= an_in;
            s_an      <= an_meta;
            sseg_meta <= sseg_in;
            s_sseg    <= sseg_meta;
        end
    end

    // Change detect and saturating stability count
    always_comb begin
        sample_c  = {s_an, s_sseg};
        changed_c = (sample_c != prev_sample);
        cnt_nxt_c = cnt;
        if (changed_c) begin
            cnt_nxt_c = '0;
        end else if (cnt != CNT_W'(STABLE_CYCLES)) begin
            cnt_nxt_c = cnt + CNT_W'(1);
        end
    end

    // Stability tracking registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_sample <= {SAMPLE_W{1'b1}};
            cnt         <= '0;
        end else begin
            prev_sample <= sample_c;
            cnt         <= cnt_nxt_c;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nxt_c;
        end
    end

    // Capture once per stable run; any change re-arms
    always_comb begin
        state_nxt_c = state;
        capture_c   = 1'b0;
        case (state)
            ST_WAIT: begin
                if (cnt_nxt_c == CNT_W'(STABLE_CYCLES - 1)) begin
                    capture_c   = 1'b1;
                    state_nxt_c = ST_HELD;
                end
            end
            ST_HELD: begin
                if (changed_c) begin
                    state_nxt_c = ST_WAIT;
                end
            end
            default: state_nxt_c = ST_WAIT;
        endcase
    end

    // Anode strobe must select exactly one digit
    always_comb begin
        an_ok_c = 1'b1;
        slot_c  = 2'd0;
        case (s_an)
            4'b1110: slot_c = 2'd0;
            4'b1101: slot_c = 2'd1;
            4'b1011: slot_c = 2'd2;
            4'b0111: slot_c = 2'd3;
            default: an_ok_c = 1'b0;
        endcase
        slot_mask_c = 4'b0001 << slot_c;
    end

    // Shadow slots, seen mask and frame publish
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
            end
            seen        <= '0;
            frame_pend  <= 1'b0;
            frame_valid <= 1'b0;
            an_err      <= 1'b0;
            hex0        <= '0;
            hex1        <= '0;
            hex2        <= '0;
            hex3        <= '0;
            dp_out      <= '0;
            blank       <= '0;
            seg_err     <= '0;
        end else begin
            frame_pend  <= 1'b0;
            frame_valid <= frame_pend;
            an_err      <= capture_c && !an_ok_c;
            if (frame_pend) begin
                hex0 <= shadow[0].nibble;
                hex1 <= shadow[1].nibble;
                hex2 <= shadow[2].nibble;
                hex3 <= shadow[3].nibble;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    dp_out[i]  <= shadow[i].dp;
                    blank[i]   <= shadow[i].blank;
                    seg_err[i] <= shadow[i].err;
                end
                seen <= '0;
            end
            if (capture_c && an_ok_c) begin
                shadow[slot_c] <= '{nibble: dec_nibble_c,
                                    dp:     ~s_sseg[SEG_DP],
                                    blank:  dec_blank_c,
                                    err:    dec_err_c};
                seen       <= seen | slot_mask_c;
                frame_pend <= ((seen | slot_mask_c) == 4'hF);
            end
        end
    end

endmodule

// File: tb/tb_sseg_mux_decoder.sv
// Directed bench for sseg_mux_decoder with STABLE_CYCLES = 4.
module tb_sseg_mux_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] an_in;
    logic [7:0] sseg_in;
    logic [3:0] hex3, hex2, hex1, hex0;
    logic [3:0] dp_out, blank, seg_err;
    logic       frame_valid, an_err;

    int checks = 0;
    int passed = 0;
    int fv_cnt = 0;
    int ae_cnt = 0;

    sseg_mux_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .an_in       (an_in),
        .sseg_in     (sseg_in),
        .hex3        (hex3),
        .hex2        (hex2),
        .hex1        (hex1),
        .hex0        (hex0),
        .dp_out      (dp_out),
        .blank       (blank),
        .seg_err     (seg_err),
        .frame_valid (frame_valid),
        .an_err      (an_err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge
    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (an_err)      ae_cnt++;
    end

    typedef struct {
        string       name;
        logic [31:0] s;      // {d3,d2,d1,d0} segment bytes
        logic [15:0] h;      // {hex3,hex2,hex1,hex0}
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic [3:0]  er;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        an_in   = a;
        sseg_in = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] a;
        a = 4'hF;
        a[d] = 1'b0;
        return a;
    endfunction

    task automatic digit(input logic [31:0] s, input int d);
        hold(an_of(d), s[8*d +: 8], 10);
    endtask

    task automatic check_out(input string name, input logic [15:0] h,
                             input logic [3:0] dp, input logic [3:0] bl,
                             input logic [3:0] er);
        check({name, ".hex"},   int'({hex3, hex2, hex1, hex0}), int'(h));
        check({name, ".dp"},    int'(dp_out),  int'(dp));
        check({name, ".blank"}, int'(blank),   int'(bl));
        check({name, ".err"},   int'(seg_err), int'(er));
    endtask

    initial begin
        int fv0, ae0, lat;

        vecs[0] = '{"digits0123", 32'h86924F81, 16'h3210, 4'b0010, 4'b0000, 4'b0000};
        vecs[1] = '{"blank_err",  32'hFF24FE88, 16'h050A, 4'b0100, 4'b1000, 4'b0010};
        vecs[2] = '{"dp_mix",     32'h00B0E038, 16'h8EBF, 4'b1001, 4'b0000, 4'b0000};

        reset_n = 1'b0;
        an_in   = 4'hF;
        sseg_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst.fv", int'(frame_valid), 0);
        check("rst.an_err", int'(an_err), 0);
        check_out("rst", 16'h0, 4'h0, 4'h0, 4'h0);
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        // Table-driven full frames
        for (int v = 0; v < 3; v++) begin
            fv0 = fv_cnt;
            ae0 = ae_cnt;
            for (int d = 0; d < 4; d++) digit(vecs[v].s, d);
            check({vecs[v].name, ".fv"}, fv_cnt - fv0, 1);
            check({vecs[v].name, ".an_err"}, ae_cnt - ae0, 0);
            check_out(vecs[v].name, vecs[v].h, vecs[v].dp, vecs[v].bl, vecs[v].er);
        end

        // Short glitch on digit 2 must not be captured
        fv0 = fv_cnt;
        digit(vecs[0].s, 0);
        digit(vecs[0].s, 1);
        digit(vecs[0].s, 2);
        hold(4'b1011, 8'h9A, 2);
        digit(vecs[0].s, 2);
        digit(vecs[0].s, 3);
        check("glitch.fv", fv_cnt - fv0, 1);
        check_out("glitch", 16'h3210, 4'b0010, 4'b0000, 4'b0000);

        // Two anodes low: error pulse, no slot written
        fv0 = fv_cnt;
        ae0 = ae_cnt;
        digit(vecs[1].s, 0);
        digit(vecs[1].s, 1);
        hold(4'b1100, 8'h81, 10);
        check("badan.an_err", ae_cnt - ae0, 1);
        check("badan.fv_early", fv_cnt - fv0, 0);
        digit(vecs[1].s, 2);
        digit(vecs[1].s, 3);
        check("badan.fv", fv_cnt - fv0, 1);
        check_out("badan", vecs[1].h, vecs[1].dp, vecs[1].bl, vecs[1].er);

        // Reset mid-frame discards the partial frame
        digit(vecs[2].s, 0);
        digit(vecs[2].s, 1);
        reset_n = 1'b0;
        #2;
        check_out("midrst", 16'h0, 4'h0, 4'h0, 4'h0);
        @(posedge clk);
        #1;
        fv0 = fv_cnt;
        reset_n = 1'b1;
        digit(vecs[0].s, 2);
        digit(vecs[0].s, 3);
        check("midrst.fv", fv_cnt - fv0, 0);
        check_out("midrst.hold", 16'h0, 4'h0, 4'h0, 4'h0);
        digit(vecs[0].s, 0);
        digit(vecs[0].s, 1);
        check("postrst.fv", fv_cnt - fv0, 1);
        check_out("postrst", vecs[0].h, vecs[0].dp, vecs[0].bl, vecs[0].er);

        // Latency from digit 3 pins settling to frame_valid
        fv0 = fv_cnt;
        digit(vecs[2].s, 0);
        digit(vecs[2].s, 1);
        digit(vecs[2].s, 2);
        an_in   = 4'b0111;
        sseg_in = vecs[2].s[31:24];
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, 7);
        repeat (10) @(posedge clk);
        #1;
        check("latency.fv", fv_cnt - fv0, 1);
        check_out("latency", vecs[2].h, vecs[2].dp, vecs[2].bl, vecs[2].er);

        // Re-capture of digit 0 overwrites its shadow slot
        fv0 = fv_cnt;
        hold(4'b1110, 8'hA4, 10);
        hold(4'b1110, 8'h84, 10);
        digit(vecs[0].s, 1);
        digit(vecs[0].s, 2);
        digit(vecs[0].s, 3);
        check("overwrite.fv", fv_cnt - fv0, 1);
        check_out("overwrite", 16'h3219, 4'b0010, 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sseg_mux_decoder.md
Name: sseg_mux_decoder

Overview:
Receive-side counterpart of the multiplexed 7-segment display driver. Samples the active-low anode strobes and segment lines of a time-multiplexed 4-digit display, waits for each digit to settle, and decodes the segments back to hex nibbles and decimal points. Publishes one coherent 4-digit frame per full scan. Used for display loopback on the board and as a checker for stopwatch/display builds in simulation.

Parameters:
STABLE_CYCLES, 16, consecutive identical synchronised samples required before a digit is captured (legal range 2..255)
CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
an_in  in  4  anode strobes, active-low; an_in[i]=0 selects digit i
sseg_in  in  8  segments, active-low; [7]=dp, [6:0]={a,b,c,d,e,f,g}
hex3, hex2, hex1, hex0  out  4 each  decoded digit values of the last complete frame
dp_out  out  4  decoded decimal points (1 = lit), bit i = digit i
blank  out  4  bit i = 1 when digit i had all seven segments off
seg_err  out  4  bit i = 1 when digit i had a non-blank pattern absent from the decode table
frame_valid  out  1  one-cycle pulse when hex*/dp_out/blank/seg_err update
an_err  out  1  one-cycle pulse when a settled anode pattern is not exactly one-low

Behaviour:
- Clock is clk. Reset is asynchronous, active-low (reset_n); all flops clear on assertion.
- Reset values: hex3..hex0=0, dp_out=0, blank=0, seg_err=0, frame_valid=0, an_err=0; internal seen mask=0; state=WAIT.
- Input sync: an_in and sseg_in pass through a 2-flop synchroniser → s_an, s_sseg (2 cycles of latency).
- Stability counter cnt: cleared when {s_an,s_sseg} differs from its previous-cycle value; otherwise increments, saturating at STABLE_CYCLES.
- FSM states:
  WAIT: when cnt reaches STABLE_CYCLES-1 on the cycle being evaluated (i.e. the STABLE_CYCLES-th identical sample) → evaluate the sample, go to HELD.
  HELD: no re-capture; any change of {s_an,s_sseg} (cnt cleared) → WAIT.
- Evaluation: s_an must be exactly one-low (1110, 1101, 1011, 0111).
  Valid: write slot i of the shadow registers (nibble, dp=~s_sseg[7], blank, err), then set seen[i].
  Invalid (including 1111 and multiple lows): no slot written; an_err pulses on the next cycle.
- Decode table, {a..g} active-low: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  1111111 → blank=1, nibble=0, err=0.
  Any other pattern → err=1, nibble=0, blank=0.
  dp is decoded independently of a..g.
- Frame completion: on the cycle after a capture makes seen==1111:
  - shadow registers copy to the outputs
  - frame_valid=1 for exactly one cycle
  - seen clears
- A re-capture of an already-seen slot before the frame completes overwrites that shadow slot; seen is unchanged.
- Outputs hold their values between frame_valid pulses.
- Total latency from the last digit's pins becoming stable to the frame_valid pulse = 2 + STABLE_CYCLES + 1 cycles.
- Glitch shorter than STABLE_CYCLES samples: cnt clears and the FSM returns to WAIT. After the glitch, the original pattern must re-stabilise and is captured again, overwriting the same slot with identical data.
- reset_n asserted mid-frame: partial frame discarded. Outputs clear asynchronously; the first frame_valid after release requires four fresh captures.

Decomposition:
- Shared package sseg_pkg holds: segment-bit index constants, the 16-entry hex-to-segment pattern constants, SEG_BLANK. The display driver reuses the same constants so encode and decode cannot drift.
- One natural sub-module: sseg_to_hex, a pure combinational 7-bit pattern → {nibble, blank, err} decoder.
- Synchroniser, stability counter, FSM and shadow/output registers stay in the top.

Test Plan:
- STABLE_CYCLES=4. Hold an=1110/sseg=1_0000001, then 1101/0_1001111, 1011/1_0010010, 0111/1_0000110, 10 cycles each. Expect one frame_valid; hex0..3=0,1,2,3; dp_out=0010; blank=0; seg_err=0.
- Glitch: during the digit-2 hold, flip sseg_in[3] for 2 cycles. Expect no capture of the glitch value, hex2=2 in the frame, exactly one frame_valid.
- Blank/error: digit3 sseg=1_1111111, digit1 sseg=1_1111110. Expect blank=1000, seg_err=0010, hex1=0, hex3=0.
- Bad anode: hold an=1100 for 10 cycles. Expect one an_err pulse, no slot written, no frame_valid until all four legal digits are seen.
- Reset mid-frame: capture digits 0 and 1, pulse reset_n low for 1 cycle, then drive digits 2 and 3 only. Expect outputs 0 and no frame_valid. Then drive all four digits: expect frame_valid exactly 2+4+1 cycles after digit 3 settles at the pins.
- Overwrite: capture digit0=5, then digit0=9, then digits 1-3. Expect hex0=9 with a single frame_valid.
